// File: rtl/uart_tx_response_scheduler.sv
// Response queue between the datapath and the UART transmitter: buffers 1-byte register reads
// and 2-byte ALU results and hands them to the TX a byte at a time using the busy-flag handshake.
module uart_tx_response_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ALU_result_valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_result,
    input  logic                    read_data_valid,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    transmitter_busy_synchronized,
    output logic [DATA_WIDTH-1:0]   transmitter_parallel_data,
    output logic                    transmitter_parallel_data_valid,
    output logic                    UART_receiver_controller_enable,
    output logic                    overflow,
    output logic                    fifo_empty
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int WW = 2 * DATA_WIDTH;
    localparam int EW = WW + 2;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    logic                  pop;
    logic                  empty;
    logic                  more_bytes;
    logic [PW-1:0]         occ;
    logic [PW:0]           free_slots;
    logic [PW:0]           slots_left;
    logic [EW-1:0]         head;
    logic [1:0]            head_len;
    logic [WW-1:0]         head_word;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign occ        = wr_ptr_q - rd_ptr_q;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign head_len   = head[EW-1:WW];
    assign head_word  = head[WW-1:0];
    assign more_bytes = (({1'b0, byte_idx_q} + 2'd1) < head_len);
    // A pop on this edge frees its slot before the pushes are considered.
    assign free_slots = (PW+1)'(FIFO_DEPTH) - {1'b0, occ} + {{PW{1'b0}}, pop};

    // FIFO push: ALU entry takes the first free slot, read entry the next one.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = 1'b0;
        slots_left = free_slots;
        if (ALU_result_valid) begin
            if (slots_left != '0) begin
                mem_d[wr_ptr_d[AW-1:0]] = {2'd2, ALU_result};
                wr_ptr_d   = wr_ptr_d + PW'(1);
                slots_left = slots_left - (PW+1)'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (read_data_valid) begin
            if (slots_left != '0) begin
                mem_d[wr_ptr_d[AW-1:0]] = {2'd1, {DATA_WIDTH{1'b0}}, read_data};
                wr_ptr_d = wr_ptr_d + PW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // TX FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // TX FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty) state_d = LOAD;
            LOAD:      state_d = WAIT_BUSY;
            WAIT_BUSY: if (transmitter_busy_synchronized) state_d = WAIT_DONE;
            WAIT_DONE: if (!transmitter_busy_synchronized) state_d = more_bytes ? LOAD : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // TX FSM: datapath/outputs
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        byte_idx_d = byte_idx_q;
        pop        = 1'b0;
        case (state_q)
            LOAD: begin
                data_d  = byte_idx_q ? head_word[WW-1:DATA_WIDTH] : head_word[DATA_WIDTH-1:0];
                valid_d = 1'b1;
            end
            WAIT_BUSY: if (transmitter_busy_synchronized) valid_d = 1'b0;
            WAIT_DONE: begin
                if (!transmitter_busy_synchronized) begin
                    if (more_bytes) begin
                        byte_idx_d = 1'b1;
                    end else begin
                        byte_idx_d = 1'b0;
                        pop        = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            byte_idx_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign transmitter_parallel_data       = data_q;
    assign transmitter_parallel_data_valid = valid_q;
    assign UART_receiver_controller_enable = (state_q == IDLE) && empty;
    assign overflow                        = overflow_q;
    assign fifo_empty                      = empty;

endmodule

// File: tb/tb_uart_tx_response_scheduler.sv
// Directed bench for uart_tx_response_scheduler: plays the TX busy handshake by hand and
// checks byte order, latency, enable gating, overflow and async reset against fixed values.
module tb_uart_tx_response_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        ALU_result_valid;
    logic [15:0] ALU_result;
    logic        read_data_valid;
    logic [7:0]  read_data;
    logic        transmitter_busy_synchronized;
    logic [7:0]  transmitter_parallel_data;
    logic        transmitter_parallel_data_valid;
    logic        UART_receiver_controller_enable;
    logic        overflow;
    logic        fifo_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_response_scheduler #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .ALU_result_valid                (ALU_result_valid),
        .ALU_result                      (ALU_result),
        .read_data_valid                 (read_data_valid),
        .read_data                       (read_data),
        .transmitter_busy_synchronized   (transmitter_busy_synchronized),
        .transmitter_parallel_data       (transmitter_parallel_data),
        .transmitter_parallel_data_valid (transmitter_parallel_data_valid),
        .UART_receiver_controller_enable (UART_receiver_controller_enable),
        .overflow                        (overflow),
        .fifo_empty                      (fifo_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (transmitter_parallel_data_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, {31'd0, transmitter_parallel_data_valid}, 32'd1);
    endtask

    // TX model: go busy 3 cycles after valid, stay busy 10 cycles, then drop.
    task automatic serve(input logic [7:0] exp, input string tag);
        wait_valid(tag);
        chk({tag, "_data"}, {24'd0, transmitter_parallel_data}, {24'd0, exp});
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, {23'd0, transmitter_parallel_data_valid, transmitter_parallel_data},
            {23'd0, 1'b1, exp});
        transmitter_busy_synchronized = 1'b1;
        @(negedge clk);
        chk({tag, "_vld_lo"}, {31'd0, transmitter_parallel_data_valid}, 32'd0);
        chk({tag, "_stable"}, {24'd0, transmitter_parallel_data}, {24'd0, exp});
        repeat (9) @(negedge clk);
        transmitter_busy_synchronized = 1'b0;
        @(negedge clk);
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (transmitter_parallel_data_valid !== 1'b0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ALU_result_valid = 1'b0;
        ALU_result = '0;
        read_data_valid = 1'b0;
        read_data = '0;
        transmitter_busy_synchronized = 1'b0;
        #2;
        chk("rst_data", {24'd0, transmitter_parallel_data}, 32'd0);
        chk("rst_valid", {31'd0, transmitter_parallel_data_valid}, 32'd0);
        chk("rst_enable", {31'd0, UART_receiver_controller_enable}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: ALU word, LSB first, 2-cycle latency, enable low across both bytes
        ALU_result_valid = 1'b1; ALU_result = 16'hE7A6;
        @(negedge clk);
        ALU_result_valid = 1'b0;
        chk("t1_empty", {31'd0, fifo_empty}, 32'd0);
        chk("t1_en_lo", {31'd0, UART_receiver_controller_enable}, 32'd0);
        @(negedge clk);
        chk("t1_lat_lo", {31'd0, transmitter_parallel_data_valid}, 32'd0);
        @(negedge clk);
        chk("t1_lat_hi", {31'd0, transmitter_parallel_data_valid}, 32'd1);
        serve(8'hA6, "t1_b0");
        chk("t1_en_mid", {31'd0, UART_receiver_controller_enable}, 32'd0);
        serve(8'hE7, "t1_b1");
        chk("t1_en_end", {31'd0, UART_receiver_controller_enable}, 32'd1);
        chk("t1_empty_end", {31'd0, fifo_empty}, 32'd1);

        // 2: single read byte
        read_data_valid = 1'b1; read_data = 8'h79;
        @(negedge clk);
        read_data_valid = 1'b0;
        serve(8'h79, "t2_b0");
        chk("t2_en", {31'd0, UART_receiver_controller_enable}, 32'd1);
        quiet("t2_one_window", 6);

        // 3: same-cycle ALU + read
        ALU_result_valid = 1'b1; ALU_result = 16'h1234;
        read_data_valid = 1'b1; read_data = 8'h56;
        @(negedge clk);
        ALU_result_valid = 1'b0; read_data_valid = 1'b0;
        chk("t3_no_ovf", {31'd0, overflow}, 32'd0);
        serve(8'h34, "t3_b0");
        serve(8'h12, "t3_b1");
        serve(8'h56, "t3_b2");
        chk("t3_en", {31'd0, UART_receiver_controller_enable}, 32'd1);

        // 4: fill 4 entries while TX is held busy, 5th push overflows
        transmitter_busy_synchronized = 1'b1;
        read_data_valid = 1'b1; read_data = 8'h11;
        @(negedge clk); read_data = 8'h22;
        @(negedge clk); read_data = 8'h33;
        @(negedge clk);
        chk("t4_head", {23'd0, transmitter_parallel_data_valid, transmitter_parallel_data},
            {23'd0, 1'b1, 8'h11});
        read_data = 8'h44;
        @(negedge clk);
        chk("t4_pre_ovf", {31'd0, overflow}, 32'd0);
        read_data = 8'h55;
        @(negedge clk);
        read_data_valid = 1'b0;
        chk("t4_ovf_hi", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        chk("t4_ovf_lo", {31'd0, overflow}, 32'd0);
        transmitter_busy_synchronized = 1'b0;
        serve(8'h22, "t4_b1");
        serve(8'h33, "t4_b2");
        serve(8'h44, "t4_b3");
        quiet("t4_no_5th", 8);
        chk("t4_empty", {31'd0, fifo_empty}, 32'd1);

        // 5: async reset during WAIT_DONE of an ALU word
        ALU_result_valid = 1'b1; ALU_result = 16'hABCD;
        @(negedge clk);
        ALU_result_valid = 1'b0;
        wait_valid("t5");
        chk("t5_data", {24'd0, transmitter_parallel_data}, 32'hCD);
        transmitter_busy_synchronized = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_data", {24'd0, transmitter_parallel_data}, 32'd0);
        chk("t5_rst_valid", {31'd0, transmitter_parallel_data_valid}, 32'd0);
        chk("t5_rst_en", {31'd0, UART_receiver_controller_enable}, 32'd1);
        chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("t5_rst_empty", {31'd0, fifo_empty}, 32'd1);
        @(negedge clk);
        transmitter_busy_synchronized = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        quiet("t5_no_resend", 12);
        chk("t5_en_after", {31'd0, UART_receiver_controller_enable}, 32'd1);

        // 6: 3 queued, then ALU+read with one free slot
        transmitter_busy_synchronized = 1'b1;
        read_data_valid = 1'b1; read_data = 8'h61;
        @(negedge clk); read_data = 8'h62;
        @(negedge clk); read_data = 8'h63;
        @(negedge clk);
        chk("t6_head", {23'd0, transmitter_parallel_data_valid, transmitter_parallel_data},
            {23'd0, 1'b1, 8'h61});
        read_data = 8'h7C;
        ALU_result_valid = 1'b1; ALU_result = 16'h7A7B;
        @(negedge clk);
        read_data_valid = 1'b0; ALU_result_valid = 1'b0;
        chk("t6_ovf_hi", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        chk("t6_ovf_lo", {31'd0, overflow}, 32'd0);
        transmitter_busy_synchronized = 1'b0;
        serve(8'h62, "t6_b1");
        serve(8'h63, "t6_b2");
        serve(8'h7B, "t6_b3");
        serve(8'h7A, "t6_b4");
        quiet("t6_no_drop", 8);
        chk("t6_en", {31'd0, UART_receiver_controller_enable}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
